mod21_rr_sched: RTL and testbench



---
 rtl/mod21_pkg.sv | 26 ++
 rtl/mod21_rr_sched_if.sv | 28 ++
 rtl/mod21_fold.sv | 28 ++
 rtl/mod21_rr_sched.sv | 137 +++++++++++++
 tb/tb_mod21_rr_sched.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mod21_pkg.sv
// mod21_pkg: shared constants, FSM state type and the fold helper for the
// mod-21 residue scheduler.
// Ports: none (package). Optional build macro: MOD21_FOLD_REG_EN (adds FOLD2 state).
package mod21_pkg;

  localparam int MOD21   = 21;
  localparam int CHUNK_W = 6;
  localparam int TOT_W   = 9;
  localparam int ACC_W   = 7;
  localparam int OP_W    = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FOLD  = 3'd1,
    FOLD2 = 3'd2,
    CORR  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Second fold step: 64 == 1 (mod 21), so the bits above the low chunk are
  // simply added back in. A 9-bit total folds to at most 63 + 4 = 67.
  function automatic logic [ACC_W-1:0] fold_tot(input logic [TOT_W-1:0] tot);
    return ACC_W'(tot[CHUNK_W-1:0]) + ACC_W'(tot[TOT_W-1:CHUNK_W]);
  endfunction

endpackage

// File: rtl/mod21_rr_sched_if.sv
// mod21_rr_sched_if: requester/consumer bundle for the shared mod-21 unit.
// Signals: req_valid/req_data/req_ready (NREQ requesters), res_valid/res_ready,
//          res_id/res_value (tagged residue), busy. master = clients, slave = scheduler.
interface mod21_rr_sched_if #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
);

  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [ID_W-1:0]      res_id;
  logic [4:0]           res_value;
  logic                 busy;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_id, res_value, busy
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_id, res_value, busy
  );

endinterface

// File: rtl/mod21_fold.sv
// mod21_fold: combinational chunk fold of a 32-bit operand toward its residue mod 21.
// Ports: i_op (32b operand) -> o_tot (9b sum of 6-bit chunks, max 318);
//        i_tot (9b) -> o_acc (7b, max 67). i_tot is split out so a pipeline register may sit between.
module mod21_fold
  import mod21_pkg::*;
(
  input  logic [OP_W-1:0]  i_op,
  input  logic [TOT_W-1:0] i_tot,
  output logic [TOT_W-1:0] o_tot,
  output logic [ACC_W-1:0] o_acc
);

  localparam int NFULL = OP_W / CHUNK_W;  // five full 6-bit chunks, then a 2-bit tail

  logic [TOT_W-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int c = 0; c < NFULL; c++) begin
      w_sum = w_sum + TOT_W'(i_op[c*CHUNK_W +: CHUNK_W]);
    end
    w_sum = w_sum + TOT_W'(i_op[OP_W-1:NFULL*CHUNK_W]);
  end

  assign o_tot = w_sum;
  assign o_acc = fold_tot(i_tot);

endmodule

// File: rtl/mod21_rr_sched.sv
// mod21_rr_sched: round-robin scheduler sharing one iterative mod-21 residue unit.
// Ports: clk, rst (sync, active-high); bus (slave modport): per-requester valid/data/ready,
//        tagged result res_valid/res_ready/res_id/res_value, busy.
// Latency grant T -> res_valid at T+3+k (k = 0..3 corrections); MOD21_FOLD_REG_EN adds one FOLD2 cycle.
// Backpressure: res_valid/res_id/res_value hold until res_ready; no grant while not IDLE.
module mod21_rr_sched
  import mod21_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  mod21_rr_sched_if.slave   bus
);

  localparam logic [ID_W:0]    NREQ_L  = (ID_W+1)'(NREQ);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NREQ-1);
  localparam logic [ACC_W-1:0] MOD21_A = ACC_W'(MOD21);

  state_t              r_state;
  state_t              w_next;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [OP_W-1:0]     r_op_q;
  logic [ID_W-1:0]     r_id_q;
  logic [ACC_W-1:0]    r_acc;

  logic                w_any;
  logic [ID_W-1:0]     w_gnt_idx;
  logic [ID_W:0]       w_scan;
  logic                w_hs;
  logic [TOT_W-1:0]    w_tot;
  logic [TOT_W-1:0]    w_tot_in;
  logic [ACC_W-1:0]    w_acc;

`ifdef MOD21_FOLD_REG_EN
  logic [TOT_W-1:0]    r_tot;
  assign w_tot_in = r_tot;
`else
  assign w_tot_in = w_tot;
`endif

  mod21_fold u_fold (
    .i_op  (r_op_q),
    .i_tot (w_tot_in),
    .o_tot (w_tot),
    .o_acc (w_acc)
  );

  // Round-robin search: first valid requester at or after r_rr_ptr, wrapping.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_scan = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
      if (w_scan >= NREQ_L) begin
        w_scan = w_scan - NREQ_L;
      end
      if (!w_any && bus.req_valid[w_scan[ID_W-1:0]]) begin
        w_any     = 1'b1;
        w_gnt_idx = w_scan[ID_W-1:0];
      end
    end
  end

  assign w_hs = (r_state == IDLE) && w_any;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_any) w_next = FOLD;
`ifdef MOD21_FOLD_REG_EN
      FOLD:  w_next = FOLD2;
      FOLD2: w_next = CORR;
`else
      FOLD:  w_next = CORR;
`endif
      CORR: if (r_acc < MOD21_A) w_next = DONE;
      DONE: if (bus.res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.req_ready = '0;
    if (w_hs) begin
      bus.req_ready = NREQ'(1) << w_gnt_idx;
    end
    bus.busy      = (r_state != IDLE);
    bus.res_valid = (r_state == DONE);
    bus.res_value = r_acc[4:0];
    bus.res_id    = r_id_q;
  end

  // Datapath: operand capture, fold and correction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_op_q   <= '0;
      r_id_q   <= '0;
      r_acc    <= '0;
`ifdef MOD21_FOLD_REG_EN
      r_tot    <= '0;
`endif
    end else begin
      if (w_hs) begin
        r_op_q   <= bus.req_data[{w_gnt_idx, 5'b0} +: OP_W];
        r_id_q   <= w_gnt_idx;
        r_rr_ptr <= (w_gnt_idx == LAST_ID) ? '0 : w_gnt_idx + 1'b1;
      end
      case (r_state)
`ifdef MOD21_FOLD_REG_EN
        FOLD:  r_tot <= w_tot;
        FOLD2: r_acc <= w_acc;
`else
        FOLD:  r_acc <= w_acc;
`endif
        // Compare guards the subtract, so it never underflows; at most 3 passes from 67.
        CORR: if (r_acc >= MOD21_A) r_acc <= r_acc - MOD21_A;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod21_rr_sched.sv
// tb_mod21_rr_sched: randomized and directed stimulus with a scoreboard checked by a
// monitor against a reference model (operand % 21, round-robin order, k-dependent latency).
// Ports: none (top-level bench).
module tb_mod21_rr_sched;

  localparam int NREQ = 4;
  localparam int ID_W = 2;
`ifdef MOD21_FOLD_REG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  typedef struct {
    int id;
    int value;
    int exp_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod21_rr_sched_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

  mod21_rr_sched #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int model_ptr = 0;
  exp_t sb[$];
  logic [NREQ-1:0] last_grant = '0;
  logic prev_v = 1'b0;
  logic [4:0] prev_val = '0;
  logic [ID_W-1:0] prev_id = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Number of subtract-21 passes, derived from the fold rule with plain arithmetic.
  function automatic int ref_k(input logic [31:0] d);
    int tot, acc;
    tot = 0;
    for (int c = 0; c < 5; c++) tot += int'((d >> (6*c)) & 32'h3F);
    tot += int'(d >> 30);
    acc = (tot % 64) + (tot / 64);
    return acc / 21;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      model_ptr  = 0;
      prev_v     = 1'b0;
      last_grant = '0;
    end else begin
      chk($countones(bus.req_ready) <= 1, "onehot", bus.req_ready, 0);
      if (bus.busy) chk(bus.req_ready == 0, "grant_while_busy", bus.req_ready, 0);
      if (!bus.busy && bus.req_valid != 0)
        chk(bus.req_ready != 0, "idle_no_grant", bus.req_ready, 1);
      if (bus.req_ready != 0) begin
        int gi, eg;
        logic [31:0] d;
        exp_t e;
        gi = 0;
        eg = -1;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) gi = i;
        for (int i = 0; i < NREQ; i++)
          if (eg < 0 && bus.req_valid[(model_ptr + i) % NREQ]) eg = (model_ptr + i) % NREQ;
        chk(gi == eg, "grant_order", gi, eg);
        chk(bus.req_valid[gi] == 1'b1, "grant_to_invalid", 0, 1);
        d = bus.req_data[gi*32 +: 32];
        e.id      = gi;
        e.value   = int'(d % 32'd21);
        e.exp_cyc = cyc + 3 + EXTRA + ref_k(d);
        sb.push_back(e);
        model_ptr = (gi + 1) % NREQ;
      end
      last_grant = bus.req_valid & bus.req_ready;

      if (prev_v) begin
        chk(bus.res_valid == 1'b1, "valid_dropped", bus.res_valid, 1);
        chk(bus.res_value == prev_val, "value_stable", bus.res_value, prev_val);
        chk(bus.res_id == prev_id, "id_stable", bus.res_id, prev_id);
      end
      if (bus.res_valid) begin
        if (!prev_v) begin
          if (sb.size() == 0) chk(1'b0, "unexpected_result", bus.res_value, -1);
          else chk(cyc == sb[0].exp_cyc, "latency", cyc, sb[0].exp_cyc);
        end
        if (bus.res_ready && sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk(int'(bus.res_value) == e.value, "res_value", bus.res_value, e.value);
          chk(int'(bus.res_id) == e.id, "res_id", bus.res_id, e.id);
        end
      end
      prev_v   = bus.res_valid && !bus.res_ready;
      prev_val = bus.res_value;
      prev_id  = bus.res_id;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (!bus.busy && sb.size() == 0 && bus.req_valid == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(ok, "idle_timeout", ok, 1);
  endtask

  task automatic send_one(input int id, input logic [31:0] d);
    bit got;
    got = 1'b0;
    bus.req_data[id*32 +: 32] = d;
    bus.req_valid[id] = 1'b1;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (last_grant[id]) begin
        got = 1'b1;
        break;
      end
    end
    bus.req_valid[id] = 1'b0;
    chk(got, "grant_timeout", got, 1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'd20;
      2: return 32'd21;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 100));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int order[$];
    int remaining[NREQ];
    bit done;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk(bus.req_ready == 0, "rst_req_ready", bus.req_ready, 0);
    chk(bus.res_valid == 0, "rst_res_valid", bus.res_valid, 0);
    chk(bus.res_value == 0, "rst_res_value", bus.res_value, 0);
    chk(bus.res_id == 0, "rst_res_id", bus.res_id, 0);
    chk(bus.busy == 0, "rst_busy", bus.busy, 0);
    rst = 1'b0;

    // Directed operands: 20, 21, 1000, 0xFFFFFFFF (k = 0..3)
    bus.res_ready = 1'b1;
    send_one(0, 32'd20);         wait_idle();
    send_one(1, 32'd21);         wait_idle();
    send_one(2, 32'd1000);       wait_idle();
    send_one(3, 32'hFFFF_FFFF);  wait_idle();

    // All requesters continuously valid: rotation 0,1,2,3,0,...
    for (int i = 0; i < NREQ; i++) bus.req_data[i*32 +: 32] = $urandom;
    bus.req_valid = '1;
    for (int n = 0; n < 200 && order.size() < 12; n++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (last_grant[i]) begin
          order.push_back(i);
          bus.req_data[i*32 +: 32] = $urandom;
        end
      end
    end
    bus.req_valid = '0;
    chk(order.size() == 12, "rotation_count", order.size(), 12);
    foreach (order[j]) chk(order[j] == j % NREQ, "rotation", order[j], j % NREQ);
    wait_idle();

    // Consumer stall in DONE with another requester waiting
    bus.res_ready = 1'b0;
    send_one(2, 32'd12345);
    done = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.res_valid) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk(done, "stall_reach_done", done, 1);
    bus.req_data[31:0] = 32'd777;
    bus.req_valid[0] = 1'b1;
    repeat (5) begin
      tick();
      chk(bus.req_ready == 0, "stall_no_grant", bus.req_ready, 0);
    end
    bus.res_ready = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (last_grant[0]) begin
        done = 1'b1;
        break;
      end
    end
    bus.req_valid[0] = 1'b0;
    chk(done, "post_stall_grant", done, 1);
    wait_idle();

    // Reset during CORR
    send_one(1, 32'hFFFF_FFFF);   // returns in FOLD
    tick();                       // now in first CORR
    chk(bus.busy == 1'b1, "in_corr_busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk(bus.busy == 0, "corr_rst_busy", bus.busy, 0);
    chk(bus.res_valid == 0, "corr_rst_res_valid", bus.res_valid, 0);
    chk(bus.res_value == 0, "corr_rst_res_value", bus.res_value, 0);
    bus.req_data[31:0]  = 32'd5;
    bus.req_data[95:64] = 32'd6;
    bus.req_valid = 4'b0101;
    tick();
    chk(last_grant == 4'b0001, "ptr_after_rst", last_grant, 1);
    bus.req_valid[0] = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (last_grant[2]) begin
        done = 1'b1;
        break;
      end
    end
    bus.req_valid[2] = 1'b0;
    chk(done, "second_after_rst", done, 1);
    wait_idle();

    // Randomized traffic with consumer backpressure and withdrawn requests
    for (int i = 0; i < NREQ; i++) remaining[i] = 50;
    done = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      bit all_done;
      tick();
      bus.res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (last_grant[i]) begin
          bus.req_valid[i] = 1'b0;
          remaining[i]--;
        end else if (bus.req_valid[i] && $urandom_range(0, 31) == 0) begin
          bus.req_valid[i] = 1'b0;
        end else if (!bus.req_valid[i] && remaining[i] > 0 && $urandom_range(0, 2) == 0) begin
          bus.req_data[i*32 +: 32] = pick();
          bus.req_valid[i] = 1'b1;
        end
      end
      all_done = 1'b1;
      for (int i = 0; i < NREQ; i++) if (remaining[i] > 0) all_done = 1'b0;
      if (all_done && bus.req_valid == 0 && sb.size() == 0 && !bus.busy) begin
        done = 1'b1;
        break;
      end
    end
    chk(done, "random_timeout", done, 1);
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
